// File: rtl/snake_sprite_compositor.sv
// Three-stage per-pixel compositor: hit-test and ROM addressing, ROM read, colour resolve.
// Layers apple > head > body > grass; whole-frame WIN/LOSE overlay latched at pixel (0,0).
module snake_sprite_compositor #(
    parameter int                 COORD_W    = 11,
    parameter int                 MAX_SEG    = 23,
    parameter int                 BLK_LOG2   = 5,
    parameter int                 RGB_W      = 4,
    parameter int                 SCREEN_W   = 1440,
    parameter int                 SCREEN_H   = 900,
    parameter logic [3*RGB_W-1:0] KEY_COLOR  = 12'h000,
    parameter logic [3*RGB_W-1:0] LOSE_COLOR = 12'hF00,
    parameter logic [3*RGB_W-1:0] WIN_COLOR  = 12'h0F0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_valid,
    input  logic [COORD_W-1:0]                   curr_x,
    input  logic [COORD_W-1:0]                   curr_y,
    input  logic [MAX_SEG*COORD_W-1:0]           snakepos_x,
    input  logic [MAX_SEG*COORD_W-1:0]           snakepos_y,
    input  logic [$clog2(MAX_SEG+1)-1:0]         length,
    input  logic [COORD_W-1:0]                   applepos_x,
    input  logic [COORD_W-1:0]                   applepos_y,
    input  logic [1:0]                           head_dir,
    input  logic                                 lose,
    input  logic                                 win,
    output logic [2*BLK_LOG2-1:0]                apple_addr,
    output logic [2*BLK_LOG2-1:0]                head_addr,
    output logic [2*BLK_LOG2-1:0]                body_addr,
    output logic [$clog2(SCREEN_W*SCREEN_H)-1:0] grass_addr,
    input  logic [3*RGB_W-1:0]                   apple_pix,
    input  logic [3*RGB_W-1:0]                   head_pix,
    input  logic [3*RGB_W-1:0]                   body_pix,
    input  logic [3*RGB_W-1:0]                   grass_pix,
    output logic                                 out_valid,
    output logic [RGB_W-1:0]                     draw_r,
    output logic [RGB_W-1:0]                     draw_g,
    output logic [RGB_W-1:0]                     draw_b
);
    localparam int BLK   = 1 << BLK_LOG2;
    localparam int LEN_W = $clog2(MAX_SEG+1);
    localparam int GA_W  = $clog2(SCREEN_W*SCREEN_H);
    localparam int CW    = 3*RGB_W;

    typedef enum logic [1:0] {ST_PLAY, ST_WIN, ST_LOSE} state_t;
    typedef enum logic [1:0] {LY_GRASS, LY_APPLE, LY_HEAD, LY_BODY} layer_t;

    // Extra bit keeps pos+BLK from wrapping past the coordinate range.
    function automatic logic hit(input logic [COORD_W-1:0] c, input logic [COORD_W-1:0] p);
        logic [COORD_W:0] ce, pe;
        ce = {1'b0, c};
        pe = {1'b0, p};
        return (pe <= ce) && (ce < pe + (COORD_W+1)'(BLK));
    endfunction

    state_t state_q, state_d;
    layer_t layer_nxt, layer1, layer2;
    state_t ov1, ov2;
    logic   vld1, vld2;

    logic [LEN_W-1:0]    len_c;
    logic [BLK_LOG2-1:0] au, av, hu, hv, hu_r, hv_r, bu, bv;
    logic                apple_hit, head_hit, body_hit;
    logic [31:0]         gx, gy;
    logic [GA_W-1:0]     grass_nxt;
    logic [CW-1:0]       sprite, colour;

    always_comb begin
        len_c     = (length > LEN_W'(MAX_SEG)) ? LEN_W'(MAX_SEG) : length;
        apple_hit = hit(curr_x, applepos_x) && hit(curr_y, applepos_y);
        head_hit  = (len_c != '0) && hit(curr_x, snakepos_x[0 +: COORD_W])
                                  && hit(curr_y, snakepos_y[0 +: COORD_W]);
        au = BLK_LOG2'(curr_x - applepos_x);
        av = BLK_LOG2'(curr_y - applepos_y);
        hu = BLK_LOG2'(curr_x - snakepos_x[0 +: COORD_W]);
        hv = BLK_LOG2'(curr_y - snakepos_y[0 +: COORD_W]);
        // ~u is BLK-1-u for a BLK_LOG2-bit offset.
        case (head_dir)
            2'b01:   begin hu_r = hv;  hv_r = ~hu; end
            2'b10:   begin hu_r = ~hu; hv_r = ~hv; end
            2'b11:   begin hu_r = ~hv; hv_r = hu;  end
            default: begin hu_r = hu;  hv_r = hv;  end
        endcase
    end

    // Descending scan so the lowest-index hit is the last one written.
    always_comb begin
        body_hit = 1'b0;
        bu       = '0;
        bv       = '0;
        for (int i = MAX_SEG-1; i >= 1; i--) begin
            if (i < int'(len_c) && hit(curr_x, snakepos_x[i*COORD_W +: COORD_W])
                                && hit(curr_y, snakepos_y[i*COORD_W +: COORD_W])) begin
                body_hit = 1'b1;
                bu       = BLK_LOG2'(curr_x - snakepos_x[i*COORD_W +: COORD_W]);
                bv       = BLK_LOG2'(curr_y - snakepos_y[i*COORD_W +: COORD_W]);
            end
        end
    end

    always_comb begin
        layer_nxt = LY_GRASS;
        if (apple_hit)     layer_nxt = LY_APPLE;
        else if (head_hit) layer_nxt = LY_HEAD;
        else if (body_hit) layer_nxt = LY_BODY;
        gx        = 32'(curr_x) % 32'(SCREEN_W);
        gy        = 32'(curr_y) % 32'(SCREEN_H);
        grass_nxt = GA_W'(gx + gy * 32'(SCREEN_W));
    end

    always_comb begin
        state_d = state_q;
        if (pix_valid && curr_x == '0 && curr_y == '0) begin
            if (lose)     state_d = ST_LOSE;
            else if (win) state_d = ST_WIN;
            else          state_d = ST_PLAY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_PLAY;
        else     state_q <= state_d;
    end

    always_comb begin
        case (layer2)
            LY_HEAD: sprite = head_pix;
            LY_BODY: sprite = body_pix;
            default: sprite = apple_pix;
        endcase
        colour = (layer2 == LY_GRASS || sprite == KEY_COLOR) ? grass_pix : sprite;
        case (ov2)
            ST_WIN:  colour = WIN_COLOR;
            ST_LOSE: colour = LOSE_COLOR;
            default: ;
        endcase
        if (!vld2) colour = '0;
    end

    // No back-pressure: pix_valid is carried alongside the pixel and emerges as out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apple_addr <= '0;
            head_addr  <= '0;
            body_addr  <= '0;
            grass_addr <= '0;
            layer1     <= LY_GRASS;
            layer2     <= LY_GRASS;
            ov1        <= ST_PLAY;
            ov2        <= ST_PLAY;
            vld1       <= 1'b0;
            vld2       <= 1'b0;
            out_valid  <= 1'b0;
            draw_r     <= '0;
            draw_g     <= '0;
            draw_b     <= '0;
        end else begin
            apple_addr <= {av, au};
            head_addr  <= {hv_r, hu_r};
            body_addr  <= {bv, bu};
            grass_addr <= grass_nxt;
            layer1     <= layer_nxt;
            ov1        <= state_d;
            vld1       <= pix_valid;
            layer2     <= layer1;
            ov2        <= ov1;
            vld2       <= vld1;
            out_valid  <= vld2;
            draw_r     <= colour[CW-1 -: RGB_W];
            draw_g     <= colour[RGB_W +: RGB_W];
            draw_b     <= colour[0 +: RGB_W];
        end
    end
endmodule

// File: tb/tb_snake_sprite_compositor.sv
// Self-checking bench for snake_sprite_compositor: directed scenes plus random scenes,
// compared against a geometric reference model with synchronous ROM models.
module tb_snake_sprite_compositor;
    localparam int CW = 11, MS = 23, BL = 5, RW = 4, SW = 1440, SH = 900;
    localparam int LW = 5, AW = 10, GW = 21;

    logic            clk = 1'b0;
    logic            rst;
    logic            pix_valid;
    logic [CW-1:0]   curr_x, curr_y, applepos_x, applepos_y;
    logic [MS*CW-1:0] snakepos_x, snakepos_y;
    logic [LW-1:0]   length;
    logic [1:0]      head_dir;
    logic            lose, win;
    logic [AW-1:0]   apple_addr, head_addr, body_addr;
    logic [GW-1:0]   grass_addr;
    logic [11:0]     apple_pix, head_pix, body_pix, grass_pix;
    logic            out_valid;
    logic [RW-1:0]   draw_r, draw_g, draw_b;

    int checks = 0;
    int errors = 0;
    int mstate = 0;
    logic [12:0] exp_q[$];

    snake_sprite_compositor dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .curr_x(curr_x), .curr_y(curr_y),
        .snakepos_x(snakepos_x), .snakepos_y(snakepos_y), .length(length),
        .applepos_x(applepos_x), .applepos_y(applepos_y), .head_dir(head_dir),
        .lose(lose), .win(win), .apple_addr(apple_addr), .head_addr(head_addr),
        .body_addr(body_addr), .grass_addr(grass_addr), .apple_pix(apple_pix),
        .head_pix(head_pix), .body_pix(body_pix), .grass_pix(grass_pix),
        .out_valid(out_valid), .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: every address that is a multiple of 9 holds the key colour.
    function automatic logic [11:0] rom_val(input int salt, input int a);
        if (a % 9 == 0) return 12'h000;
        return 12'(((a * salt + salt * 17) % 4095) + 1);
    endfunction

    function automatic logic [11:0] grass_val(input int a);
        return 12'((a * 11 + 5) % 4096);
    endfunction

    always_ff @(posedge clk) begin
        apple_pix <= rom_val(3, int'(apple_addr));
        head_pix  <= rom_val(5, int'(head_addr));
        body_pix  <= rom_val(7, int'(body_addr));
        grass_pix <= grass_val(int'(grass_addr));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_seg(input int i, input int x, input int y);
        snakepos_x[i*CW +: CW] = CW'(x);
        snakepos_y[i*CW +: CW] = CW'(y);
    endtask

    function automatic bit inside_blk(input int c, input int p);
        return (p <= c) && (c < p + 32);
    endfunction

    // One pixel: model it, clock it in, check its addresses and the output of three pixels ago.
    task automatic step(input int x, input int y, input logic v);
        int len_c, layer, u, vv, up, vp, ga, ea, sx, sy;
        logic [11:0] col, sp;
        curr_x = CW'(x);
        curr_y = CW'(y);
        pix_valid = v;
        layer = 0; ea = 0;
        ga = (x % SW) + (y % SH) * SW;
        len_c = (int'(length) > MS) ? MS : int'(length);
        if (inside_blk(x, int'(applepos_x)) && inside_blk(y, int'(applepos_y))) begin
            layer = 1;
            ea = (y - int'(applepos_y)) * 32 + (x - int'(applepos_x));
        end else if (len_c >= 1 && inside_blk(x, int'(snakepos_x[0 +: CW]))
                                && inside_blk(y, int'(snakepos_y[0 +: CW]))) begin
            layer = 2;
            u  = x - int'(snakepos_x[0 +: CW]);
            vv = y - int'(snakepos_y[0 +: CW]);
            case (head_dir)
                2'd0: begin up = u;       vp = vv;      end
                2'd1: begin up = vv;      vp = 31 - u;  end
                2'd2: begin up = 31 - u;  vp = 31 - vv; end
                default: begin up = 31 - vv; vp = u;    end
            endcase
            ea = vp * 32 + up;
        end else begin
            for (int i = 1; i < len_c; i++) begin
                sx = int'(snakepos_x[i*CW +: CW]);
                sy = int'(snakepos_y[i*CW +: CW]);
                if (layer == 0 && inside_blk(x, sx) && inside_blk(y, sy)) begin
                    layer = 3;
                    ea = (y - sy) * 32 + (x - sx);
                end
            end
        end
        case (layer)
            1: sp = rom_val(3, ea);
            2: sp = rom_val(5, ea);
            3: sp = rom_val(7, ea);
            default: sp = 12'h000;
        endcase
        col = (layer == 0 || sp == 12'h000) ? grass_val(ga) : sp;
        if (!rst) begin
            if (v && x == 0 && y == 0) mstate = lose ? 2 : (win ? 1 : 0);
            if (mstate == 1) col = 12'h0F0;
            if (mstate == 2) col = 12'hF00;
            if (!v) col = 12'h000;
            exp_q.push_back({v, col});
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("grass_addr", 32'(grass_addr), 32'(ga));
            if (layer == 1) chk("apple_addr", 32'(apple_addr), 32'(ea));
            if (layer == 2) chk("head_addr", 32'(head_addr), 32'(ea));
            if (layer == 3) chk("body_addr", 32'(body_addr), 32'(ea));
        end
        if (exp_q.size() >= 3) chk("pixel_out", 32'({out_valid, draw_r, draw_g, draw_b}), 32'(exp_q.pop_front()));
        else chk("pixel_idle", 32'({out_valid, draw_r, draw_g, draw_b}), 32'h0);
    endtask

    task automatic flush();
        repeat (3) step(1000, 800, 1'b0);
    endtask

    task automatic park_scene();
        for (int i = 0; i < MS; i++) set_seg(i, 2000, 2000);
        applepos_x = CW'(1900);
        applepos_y = CW'(1900);
        length = LW'(5);
        head_dir = 2'd0;
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; curr_x = '0; curr_y = '0;
        lose = 1'b0; win = 1'b0;
        snakepos_x = '0; snakepos_y = '0;
        park_scene();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'({out_valid, draw_r, draw_g, draw_b}), 32'h0);
        chk("rst_addr", 32'({apple_addr, head_addr, body_addr}), 32'h0);
        chk("rst_grass", 32'(grass_addr), 32'h0);
        rst = 1'b0;

        // Apple sprite, opaque and keyed pixels.
        applepos_x = CW'(100); applepos_y = CW'(100);
        step(110, 105, 1'b1);
        chk("t1_apple_addr", 32'(apple_addr), 32'd170);
        step(100, 100, 1'b1);
        step(131, 100, 1'b1);
        flush();

        // Head rotation.
        park_scene();
        set_seg(0, 200, 200);
        head_dir = 2'd1;
        step(201, 203, 1'b1);
        chk("t2_head_addr", 32'(head_addr), 32'd963);
        head_dir = 2'd2; step(201, 203, 1'b1);
        head_dir = 2'd3; step(201, 203, 1'b1);
        head_dir = 2'd0; step(231, 231, 1'b1);
        length = '0;     step(201, 203, 1'b1);
        flush();

        // Overlapping body segments and length limits.
        park_scene();
        set_seg(1, 300, 300); set_seg(2, 300, 300);
        length = LW'(3);
        step(305, 305, 1'b1);
        chk("t3_body_addr", 32'(body_addr), 32'd165);
        length = LW'(1); step(305, 305, 1'b1);
        set_seg(1, 2000, 2000); set_seg(22, 400, 400);
        length = LW'(31); step(401, 402, 1'b1);
        length = LW'(22); step(401, 402, 1'b1);
        flush();

        // Apple over head, and no wrap at the far edge.
        park_scene();
        applepos_x = CW'(50); applepos_y = CW'(50); set_seg(0, 50, 50);
        step(60, 61, 1'b1);
        set_seg(0, 1430, 10); step(5, 12, 1'b1);
        set_seg(0, 2040, 10); step(5, 12, 1'b1);
        flush();

        // Overlay latched only at frame start.
        park_scene();
        lose = 1'b1; step(10, 10, 1'b1);
        step(0, 0, 1'b0); step(3, 3, 1'b1);
        step(0, 0, 1'b1); step(20, 30, 1'b1); step(5, 5, 1'b1);
        win = 1'b1; step(0, 0, 1'b1); step(9, 9, 1'b1);
        win = 1'b0; lose = 1'b0; step(7, 7, 1'b1);
        step(0, 0, 1'b1); step(8, 8, 1'b1);
        win = 1'b1; step(0, 0, 1'b1); step(4, 4, 1'b1);
        win = 1'b0; step(0, 0, 1'b1); step(4, 4, 1'b1);
        flush();

        // pix_valid toggling, then asynchronous reset mid-stream.
        applepos_x = CW'(0); applepos_y = CW'(0);
        for (int i = 0; i < 10; i++) step(i * 3, i, (i % 3) != 1);
        rst = 1'b1;
        #1;
        chk("async_rst_out", 32'({out_valid, draw_r, draw_g, draw_b}), 32'h0);
        chk("async_rst_addr", 32'(apple_addr), 32'h0);
        exp_q.delete();
        mstate = 0;
        step(1, 1, 1'b1); step(2, 2, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(i, 2 * i, 1'b1);
        flush();

        // Random scenes.
        for (int n = 0; n < 400; n++) begin
            if (n % 16 == 0) begin
                applepos_x = CW'($urandom_range(0, 200));
                applepos_y = CW'($urandom_range(0, 200));
                for (int i = 0; i < MS; i++)
                    set_seg(i, int'($urandom_range(0, 200)), int'($urandom_range(0, 200)));
                length   = LW'($urandom_range(0, 31));
                head_dir = 2'($urandom_range(0, 3));
                lose     = ($urandom_range(0, 3) == 0);
                win      = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 15) == 0) step(0, 0, 1'($urandom_range(0, 4) != 0));
            else step(int'($urandom_range(0, 230)), int'($urandom_range(0, 230)),
                      1'($urandom_range(0, 4) != 0));
        end
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
